// File: rtl/inert_seq.sv
// Power-up / configuration / read sequencer for the inertial sensor behind a 16-bit SPI master.
// Optional INT synchroniser enabled by defining INERT_INT_SYNC_EN.
module inert_seq #(
    parameter int DLY_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    typedef enum logic [2:0] {
        PWR_DLY,
        INIT_WR,
        INIT_WT,
        WAIT_INT,
        RD_WR,
        RD_WT,
        UPDATE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DLY_W-1:0]   r_dly_cnt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic               r_done_ff;
    logic               w_done_rise;
    logic               w_int;
    logic               w_load;
    logic [15:0]        r_cmd;
    logic [15:0]        r_ptch;
    logic [15:0]        r_az;
    logic               r_vld;
    logic [7:0]         r_byte [4];
    logic               w_unused_rd_hi;

    assign w_unused_rd_hi = &{1'b0, rd_data[15:8]};

    function automatic logic [15:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 16'h0D02;
            2'd1:    return 16'h1053;
            2'd2:    return 16'h1150;
            default: return 16'h1460;
        endcase
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 16'hA200;
            2'd1:    return 16'hA300;
            2'd2:    return 16'hAC00;
            default: return 16'hAD00;
        endcase
    endfunction

`ifdef INERT_INT_SYNC_EN
    logic r_int_s1;
    logic r_int_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_int_s1 <= 1'b0;
            r_int_s2 <= 1'b0;
        end else begin
            r_int_s1 <= INT;
            r_int_s2 <= r_int_s1;
        end
    end

    assign w_int = r_int_s2;
`else
    assign w_int = INT;
`endif

    // A done level still high from the previous transfer must not complete the next one.
    assign w_done_rise = done & ~r_done_ff;

    // State register process.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= PWR_DLY;
            r_dly_cnt <= '0;
            r_idx     <= 2'd0;
            r_done_ff <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_done_ff <= done;
            if (r_state == PWR_DLY)
                r_dly_cnt <= r_dly_cnt + 1'b1;
        end
    end

    // Next-state process.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            PWR_DLY: begin
                if (&r_dly_cnt) begin
                    w_state_nxt = INIT_WR;
                    w_idx_nxt   = 2'd0;
                end
            end
            INIT_WR: w_state_nxt = INIT_WT;
            INIT_WT: begin
                if (w_done_rise) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = WAIT_INT;
                    end else begin
                        w_state_nxt = INIT_WR;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            WAIT_INT: begin
                if (w_int) begin
                    w_state_nxt = RD_WR;
                    w_idx_nxt   = 2'd0;
                end
            end
            RD_WR: w_state_nxt = RD_WT;
            RD_WT: begin
                if (w_done_rise) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = UPDATE;
                    end else begin
                        w_state_nxt = RD_WR;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            UPDATE:  w_state_nxt = WAIT_INT;
            default: w_state_nxt = PWR_DLY;
        endcase
    end

    // Output process.
    always_comb begin
        wrt    = 1'b0;
        w_load = 1'b0;
        unique case (r_state)
            INIT_WR, RD_WR: wrt    = 1'b1;
            UPDATE:         w_load = 1'b1;
            default: ;
        endcase
    end

    // cmd is loaded on entry to a write state so it is valid with wrt and frozen until done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd  <= 16'h0000;
            r_ptch <= 16'h0000;
            r_az   <= 16'h0000;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_load;
            if (w_state_nxt == INIT_WR)
                r_cmd <= init_cmd(w_idx_nxt);
            else if (w_state_nxt == RD_WR)
                r_cmd <= rd_cmd(w_idx_nxt);
            if (w_load) begin
                r_ptch <= {r_byte[1], r_byte[0]};
                r_az   <= {r_byte[3], r_byte[2]};
            end
        end
    end

    // NOTE: the byte buffer is deliberately not reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (r_state == RD_WT && w_done_rise)
            r_byte[r_idx] <= rd_data[7:0];
    end

    assign cmd     = r_cmd;
    assign ptch_rt = r_ptch;
    assign AZ      = r_az;
    assign vld     = r_vld;

endmodule

// File: tb/tb_inert_seq.sv
// Directed self-checking bench for inert_seq (DLY_W=4) with a behavioural SPI master responder.
`timescale 1ns/1ps
module tb_inert_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    int          checks = 0;
    int          errors = 0;
    int          wrt_cnt = 0;
    int          vld_cnt = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    bit          stale = 1'b0;
    logic [15:0] cur_cmd = 16'h0000;
    logic [15:0] cmd_log [$];
    logic [7:0]  rd_b [4];
    logic [15:0] prev_ptch;
    logic [15:0] prev_az;

`ifdef INERT_INT_SYNC_EN
    localparam int INT_LAT = 3;
`else
    localparam int INT_LAT = 1;
`endif

    inert_seq #(.DLY_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (vld) vld_cnt++;

    function automatic logic [7:0] reg_byte(input logic [15:0] c);
        case (c[15:8])
            8'hA2:   return rd_b[0];
            8'hA3:   return rd_b[1];
            8'hAC:   return rd_b[2];
            8'hAD:   return rd_b[3];
            default: return 8'h00;
        endcase
    endfunction

    // SPI master model: done drops on wrt and rises 40 clocks later unless held stale.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            done     = 1'b0;
        end else if (wrt) begin
            wrt_cnt++;
            cmd_log.push_back(cmd);
            cur_cmd  = cmd;
            busy_cnt = 40;
            if (!stale) done = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                rd_data = {8'h5A, reg_byte(cur_cmd)};
                if (!stale) begin
                    done     = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts posedges until wrt is seen high; -1 if the budget runs out.
    task automatic count_to_wrt(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wrt) return;
        end
        n = -1;
    endtask

    task automatic wait_vld(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            prev_ptch = ptch_rt;
            prev_az   = AZ;
            @(negedge clk);
            if (vld) seen = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrt"}, wrt, 0);
        check({tag, "_cmd"}, cmd, 16'h0000);
        check({tag, "_vld"}, vld, 0);
        check({tag, "_ptch"}, ptch_rt, 16'h0000);
        check({tag, "_az"}, AZ, 16'h0000);
    endtask

    initial begin
        int n;
        int base;
        bit seen;
        logic [15:0] exp_init [4];
        logic [15:0] exp_rd [4];
        exp_init = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        exp_rd   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
        rd_b     = '{8'h34, 8'h12, 8'hCD, 8'hAB};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // First wrt: release edge plus 15 more clocks.
        rst_n = 1'b1;
        count_to_wrt(100, n);
        check("first_wrt_edges", n, 16);
        check("first_cmd", cmd, 16'h0D02);

        // Init sequence completes, then idles with INT low.
        repeat (300) @(negedge clk);
        check("init_wrt_cnt", wrt_cnt, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("init_cmd%0d", i), cmd_log[i], exp_init[i]);
        check("idle_wrt", wrt, 0);
        check("idle_cmd_hold", cmd, 16'h1460);

        // Single read.
        INT = 1'b1;
        count_to_wrt(20, n);
        check("int_to_wrt", n, INT_LAT);
        INT = 1'b0;
        wait_vld(400, seen);
        check("rd1_vld_seen", seen, 1);
        check("rd1_ptch", ptch_rt, 16'h1234);
        check("rd1_az", AZ, 16'hABCD);
        check("rd1_ptch_before", prev_ptch, 16'h0000);
        check("rd1_az_before", prev_az, 16'h0000);
        check("rd1_vld_latency", cyc - done_cyc, 2);
        @(negedge clk);
        check("rd1_vld_one_cycle", vld, 0);
        repeat (60) @(negedge clk);
        check("rd1_wrt_cnt", wrt_cnt, 8);
        check("rd1_vld_cnt", vld_cnt, 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd1_cmd%0d", i), cmd_log[4 + i], exp_rd[i]);

        // Back-to-back reads with INT held high.
        rd_b = '{8'h78, 8'h56, 8'h21, 8'h43};
        INT  = 1'b1;
        wait_vld(400, seen);
        check("b2b_vld_seen", seen, 1);
        check("b2b_ptch", ptch_rt, 16'h5678);
        check("b2b_az", AZ, 16'h4321);
        @(negedge clk);
        check("b2b_next_wrt", wrt, 1);
        check("b2b_vld_low", vld, 0);
        check("b2b_next_cmd", cmd, 16'hA200);
        INT = 1'b0;
        wait_vld(400, seen);
        check("b2b2_vld_seen", seen, 1);
        check("b2b2_ptch", ptch_rt, 16'h5678);
        repeat (60) @(negedge clk);
        check("b2b_wrt_cnt", wrt_cnt, 16);
        check("b2b_vld_cnt", vld_cnt, 3);

        // Stale done: done never drops, so the read never completes.
        stale = 1'b1;
        INT   = 1'b1;
        repeat (200) @(negedge clk);
        INT = 1'b0;
        check("stale_wrt_cnt", wrt_cnt, 17);
        check("stale_vld_cnt", vld_cnt, 3);
        check("stale_cmd", cmd, 16'hA200);
        check("stale_ptch_hold", ptch_rt, 16'h5678);

        // Reset recovers the hung sequencer.
        rst_n = 1'b0;
        stale = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst2");
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("reinit_wrt_cnt", wrt_cnt, 21);
        base = wrt_cnt;

        // Reset during the third read.
        INT = 1'b1;
        for (int i = 0; i < 400 && wrt_cnt < base + 3; i++) @(negedge clk);
        check("rd3_reached", wrt_cnt, base + 3);
        INT = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst3");
        check("rst3_vld_cnt", vld_cnt, 3);
        rst_n = 1'b1;
        count_to_wrt(100, n);
        check("restart_wrt_edges", n, 16);
        check("restart_cmd", cmd, 16'h0D02);
        check("restart_ptch", ptch_rt, 16'h0000);
        check("restart_az", AZ, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
